// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants and types for the pipeline stall controller.
// Holds the stall encodings, the divider FSM states and a counter-width helper.
package pipe_stall_ctrl_pkg;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // Bit map: [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB
    localparam logic [5:0] StallNone = {6{NoStop}};
    localparam logic [5:0] StallId   = {{3{NoStop}}, {3{Stop}}};
    localparam logic [5:0] StallEx   = {{2{NoStop}}, {4{Stop}}};
    localparam logic [5:0] StallMem  = {NoStop, {5{Stop}}};

    typedef enum logic [1:0] {
        StIdle,
        StDivWait,
        StDivAbort
    } div_state_e;

    // Width able to hold max_val, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_wait_cnt.sv
// Data-memory wait-state counter: each access is held for WAIT cycles,
// then gets one free cycle in which it advances.
module pipe_stall_ctrl_wait_cnt
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned WAIT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    output logic busy
);

    if (WAIT == 0) begin : g_no_wait
        logic unused_inputs;
        assign unused_inputs = ^{clk, rst, req};
        assign busy = 1'b0;
    end else begin : g_wait
        localparam int unsigned CntW = cnt_width(WAIT);

        logic [CntW-1:0] cnt_q, cnt_d;
        logic            last_q, last_d;

        assign busy = (cnt_q != '0) | (req & (cnt_q == '0) & ~last_q);

        always_comb begin
            cnt_d  = cnt_q;
            last_d = 1'b0;
            if (last_q) begin
                // Free cycle: the access advances, no stall.
                cnt_d = '0;
            end else if (cnt_q != '0) begin
                cnt_d  = cnt_q - CntW'(1);
                last_d = (cnt_q == CntW'(1));
            end else if (req) begin
                cnt_d  = CntW'(WAIT - 1);
                last_d = (WAIT == 1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q  <= '0;
                last_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                last_q <= last_d;
            end
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall controller: merges load-use, divider and data-memory wait
// stall sources into the per-stage stall vector (priority MEM > EX > ID).
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned DMEM_WAIT   = 2,
    parameter int unsigned DIV_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stallreq_id,
    input  logic       ex_div_op,
    input  logic       div_done,
    input  logic       mem_access,
    output logic       div_start,
    output logic       div_ack,
    output logic       div_cancel,
    output logic       div_err,
    output logic [5:0] stall
);

    localparam int unsigned ToW = cnt_width(DIV_TIMEOUT);
    localparam logic [ToW-1:0] ToLast = ToW'(DIV_TIMEOUT - 1);

    logic mem_stall;
    logic ex_stall;
    logic start_raw, ack_raw, cancel_raw;

    div_state_e     state_q, state_d;
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic           div_err_q, div_err_d;

    pipe_stall_ctrl_wait_cnt #(
        .WAIT (DMEM_WAIT)
    ) u_wait_cnt (
        .clk  (clk),
        .rst  (rst),
        .req  (mem_access),
        .busy (mem_stall)
    );

    // to_cnt numbers the cycles of a division with the start cycle as 0.
    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        div_err_d  = div_err_q;
        ex_stall   = 1'b0;
        start_raw  = 1'b0;
        ack_raw    = 1'b0;
        cancel_raw = 1'b0;
        unique case (state_q)
            StIdle: begin
                to_cnt_d = '0;
                if (ex_div_op && !mem_stall) begin
                    start_raw = 1'b1;
                    ex_stall  = 1'b1;
                    to_cnt_d  = ToW'(1);
                    state_d   = StDivWait;
                end
            end
            StDivWait: begin
                if (div_done && !mem_stall) begin
                    ack_raw  = 1'b1;
                    to_cnt_d = '0;
                    state_d  = StIdle;
                end else begin
                    ex_stall = 1'b1;
                    if (!div_done && to_cnt_q == ToLast) begin
                        cancel_raw = 1'b1;
                        div_err_d  = 1'b1;
                        to_cnt_d   = '0;
                        state_d    = StDivAbort;
                    end else if (to_cnt_q < ToLast) begin
                        to_cnt_d = to_cnt_q + ToW'(1);
                    end
                end
            end
            StDivAbort: begin
                // Let the faulting div drain out of EX without restarting it.
                if (!mem_stall) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            to_cnt_q  <= '0;
            div_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            div_err_q <= div_err_d;
        end
    end

    always_comb begin
        stall = StallNone;
        if (!rst) begin
            if (mem_stall) begin
                stall = StallMem;
            end else if (ex_stall) begin
                stall = StallEx;
            end else if (stallreq_id) begin
                stall = StallId;
            end
        end
    end

    assign div_start  = start_raw & ~rst;
    assign div_ack    = ack_raw & ~rst;
    assign div_cancel = cancel_raw & ~rst;
    assign div_err    = div_err_q;

endmodule
